// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Purpose : basic word type shared by the MIPS datapath blocks.
// Contents: WORD_W (machine word width) and word_t.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage : cpu_types_pkg

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Purpose : shared definitions for the imem/dmem RAM arbiter.
// Contents: arb_state_t (arbiter FSM states), default starvation bound.
package mem_arb_pkg;

    // Consecutive data grants allowed while a fetch is waiting.
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Purpose : shares one single-ported RAM between instruction fetch (imem)
//           and data access (dmem). Data wins arbitration; a bounded
//           streak counter lets a waiting fetch through after STARVE_MAX
//           consecutive data grants.
// Ports   :
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   iREN, iaddr         instruction read request / address
//   iload, iwait        instruction data (= ramload), access-not-done flag
//   dREN, dWEN          data read / write request (write wins if both)
//   daddr, dstore       data address / write data
//   dload, dwait        data read data (= ramload), access-not-done flag
//   ramREN, ramWEN      RAM read / write strobes (registered state only)
//   ramaddr, ramstore   RAM address / write data
//   ramload, ram_ack    RAM read data, one-cycle completion pulse
//   o_dbg_state         current arbiter state (arb_state_t encoding)
//   o_dbg_dstreak       current consecutive-data-grant count
//
// Handshake: a requester raises its request and holds it until its wait
// output is 0. The wait goes low for exactly the one cycle in which the RAM
// acks the granted access; load data is valid only in that cycle. Each
// access takes one arbitration cycle in IDLE plus the RAM latency, and
// back-to-back accesses always return to IDLE in between. Once granted, an
// access runs to completion even if the request drops.
module mem_arbiter
    import mem_arb_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int ADDR_W     = WORD_W
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             iREN,
    input  logic [ADDR_W-1:0]                iaddr,
    output logic [ADDR_W-1:0]                iload,
    output logic                             iwait,
    input  logic                             dREN,
    input  logic                             dWEN,
    input  logic [ADDR_W-1:0]                daddr,
    input  logic [ADDR_W-1:0]                dstore,
    output logic [ADDR_W-1:0]                dload,
    output logic                             dwait,
    output logic                             ramREN,
    output logic                             ramWEN,
    output logic [ADDR_W-1:0]                ramaddr,
    output logic [ADDR_W-1:0]                ramstore,
    input  logic [ADDR_W-1:0]                ramload,
    input  logic                             ram_ack,
    output logic [1:0]                       o_dbg_state,
    output logic [$clog2(STARVE_MAX+1)-1:0]  o_dbg_dstreak
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t         r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_store;
    logic               r_is_write;
    logic [CNT_W-1:0]   r_dstreak;

    arb_state_t         w_next_state;
    logic               w_grant_d;
    logic               w_grant_i;
    logic               w_dpend;
    logic               w_force_i;
    logic               w_busy;

    assign w_dpend = dREN | dWEN;
    // A waiting fetch overrides data once the streak has hit its bound.
    assign w_force_i = iREN & (r_dstreak == CNT_W'(STARVE_MAX));

    always_comb begin
        w_next_state = r_state;
        w_grant_d    = 1'b0;
        w_grant_i    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dpend && !w_force_i) begin
                    w_next_state = DGNT;
                    w_grant_d    = 1'b1;
                end else if (iREN) begin
                    w_next_state = IGNT;
                    w_grant_i    = 1'b1;
                end
            end
            IGNT, DGNT: begin
                if (ram_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_store    <= '0;
            r_is_write <= 1'b0;
            r_dstreak  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_d) begin
                r_addr     <= daddr;
                r_store    <= dstore;
                r_is_write <= dWEN;
                // Only data grants that actually made a fetch wait count.
                if (iREN) begin
                    if (r_dstreak != CNT_W'(STARVE_MAX)) begin
                        r_dstreak <= r_dstreak + CNT_W'(1);
                    end
                end else begin
                    r_dstreak <= '0;
                end
            end else if (w_grant_i) begin
                r_addr     <= iaddr;
                r_store    <= '0;
                r_is_write <= 1'b0;
                r_dstreak  <= '0;
            end
        end
    end

    // RAM side is a function of registered state only; no request-to-strobe path.
    assign w_busy   = (r_state != IDLE);
    assign ramREN   = w_busy & ~r_is_write;
    assign ramWEN   = w_busy & r_is_write;
    assign ramaddr  = w_busy ? r_addr : '0;
    assign ramstore = (r_state == DGNT) ? r_store : '0;

    // Waits drop only in the ack cycle of the matching grant; an ack in IDLE
    // (e.g. left over from an access abandoned by reset) is ignored.
    assign iwait = ~((r_state == IGNT) & ram_ack);
    assign dwait = ~((r_state == DGNT) & ram_ack);

    assign iload = ramload;
    assign dload = ramload;

    assign o_dbg_state   = r_state;
    assign o_dbg_dstreak = r_dstreak;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int SM = 4;

    logic        CLK;
    logic        RST;
    logic        iREN, dREN, dWEN, ram_ack;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_dstreak;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ram_ack(ram_ack),
        .o_dbg_state(dbg_state), .o_dbg_dstreak(dbg_dstreak)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: either no access in flight, or one access
    // (kind, address, data, direction) owning the RAM until acked.
    bit          m_busy   = 1'b0;
    bit          m_data   = 1'b0;
    bit          m_wr     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_store  = '0;
    int          m_streak = 0;
    bit          m_i_done = 1'b0;
    bit          m_d_done = 1'b0;
    logic [31:0] exp_q[$];

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ramREN",   32'(ramREN),   32'(m_busy && !m_wr));
            chk("ramWEN",   32'(ramWEN),   32'(m_busy && m_wr));
            chk("ramaddr",  ramaddr,       m_busy ? m_addr : 32'h0);
            chk("ramstore", ramstore,      (m_busy && m_data) ? m_store : 32'h0);
            chk("iwait",    32'(iwait),    32'(!(m_busy && !m_data && ram_ack)));
            chk("dwait",    32'(dwait),    32'(!(m_busy && m_data && ram_ack)));
            chk("iload",    iload,         ramload);
            chk("dload",    dload,         ramload);
            chk("state",    32'(dbg_state),
                32'(!m_busy ? IDLE : (m_data ? DGNT : IGNT)));
            chk("dstreak",  32'(dbg_dstreak), 32'(m_streak));
            if (m_busy && ram_ack) begin
                if (exp_q.size() > 0) chk("sb_addr", ramaddr, exp_q.pop_front());
                else chk("sb_underflow", 32'(exp_q.size()), 32'd1);
            end
        end
        m_i_done = m_busy && !m_data && ram_ack && !RST;
        m_d_done = m_busy && m_data && ram_ack && !RST;
        if (RST) begin
            m_busy = 1'b0; m_data = 1'b0; m_wr = 1'b0;
            m_addr = '0; m_store = '0; m_streak = 0;
            exp_q.delete();
        end else if (m_busy) begin
            if (ram_ack) m_busy = 1'b0;
        end else if ((dREN || dWEN) && !(iREN && m_streak == SM)) begin
            m_busy = 1'b1; m_data = 1'b1; m_wr = dWEN;
            m_addr = daddr; m_store = dstore;
            m_streak = iREN ? ((m_streak < SM) ? m_streak + 1 : SM) : 0;
            exp_q.push_back(daddr);
        end else if (iREN) begin
            m_busy = 1'b1; m_data = 1'b0; m_wr = 1'b0;
            m_addr = iaddr; m_store = '0; m_streak = 0;
            exp_q.push_back(iaddr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ram_ack = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b1;
        cyc();
        RST = 1'b0;
    endtask

    task automatic rand_inputs();
        RST = ($urandom_range(0, 199) == 0);
        if (!iREN) begin
            if ($urandom_range(0, 3) == 0) begin
                iREN = 1'b1; iaddr = $urandom & 32'hFFFF_FFFC;
            end
        end else if (m_i_done) begin
            iREN = $urandom_range(0, 1); iaddr = $urandom & 32'hFFFF_FFFC;
        end else if ($urandom_range(0, 29) == 0) begin
            iREN = 1'b0;
        end
        if (!(dREN || dWEN)) begin
            if ($urandom_range(0, 2) == 0) begin
                {dWEN, dREN} = 2'($urandom_range(1, 3));
                daddr = $urandom; dstore = $urandom;
            end
        end else if (m_d_done) begin
            if ($urandom_range(0, 1) == 0) begin
                dREN = 1'b0; dWEN = 1'b0;
            end else begin
                {dWEN, dREN} = 2'($urandom_range(1, 3));
            end
            daddr = $urandom; dstore = $urandom;
        end else if ($urandom_range(0, 29) == 0) begin
            dREN = 1'b0; dWEN = 1'b0;
        end
        if ($urandom_range(0, 9) == 0) daddr = $urandom;
        if ($urandom_range(0, 9) == 0) iaddr = $urandom;
        ram_ack = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        ramload = $urandom;
    endtask

    // ---------------- scenarios ----------------
    int seq[8];
    int exp_seq[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
    int n_done;
    int streak_at_fetch;

    initial begin
        RST = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        RST = 1'b0;
        chk_en = 1'b1;

        // reset state
        at_neg();
        chk("rst_ramREN", 32'(ramREN), 32'd0);
        chk("rst_ramWEN", 32'(ramWEN), 32'd0);
        chk("rst_ramaddr", ramaddr, 32'h0);
        chk("rst_ramstore", ramstore, 32'h0);
        chk("rst_iwait", 32'(iwait), 32'd1);
        chk("rst_dwait", 32'(dwait), 32'd1);
        chk("rst_dstreak", 32'(dbg_dstreak), 32'd0);
        cyc();

        // single fetch, ack in third granted cycle
        do_reset();
        iREN = 1; iaddr = 32'h40;
        at_neg();
        chk("fetch_idle_ren", 32'(ramREN), 32'd0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            ram_ack = (k == 2);
            ramload = (k == 2) ? 32'h8C01_0004 : 32'h0;
            at_neg();
            chk("fetch_ren", 32'(ramREN), 32'd1);
            chk("fetch_addr", ramaddr, 32'h40);
            chk("fetch_iwait", 32'(iwait), (k == 2) ? 32'd0 : 32'd1);
            if (k == 2) chk("fetch_iload", iload, 32'h8C01_0004);
            cyc();
        end
        iREN = 0; ram_ack = 0;
        at_neg();
        chk("fetch_after_ren", 32'(ramREN | ramWEN), 32'd0);
        chk("fetch_after_state", 32'(dbg_state), 32'(IDLE));
        cyc();

        // simultaneous requests, data first
        do_reset();
        iREN = 1; iaddr = 32'h40;
        dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
        cyc();
        ram_ack = 1;
        at_neg();
        chk("sim_wen", 32'(ramWEN), 32'd1);
        chk("sim_store", ramstore, 32'hDEAD_BEEF);
        chk("sim_daddr", ramaddr, 32'h100);
        chk("sim_dwait", 32'(dwait), 32'd0);
        chk("sim_iwait_d", 32'(iwait), 32'd1);
        cyc();
        dWEN = 0; ram_ack = 0;
        at_neg();
        chk("sim_iwait_idle", 32'(iwait), 32'd1);
        cyc();
        at_neg();
        chk("sim_iaddr", ramaddr, 32'h40);
        chk("sim_iren", 32'(ramREN), 32'd1);
        chk("sim_iwait_noack", 32'(iwait), 32'd1);
        cyc();
        ram_ack = 1;
        at_neg();
        chk("sim_iwait_ack", 32'(iwait), 32'd0);
        cyc();
        iREN = 0; ram_ack = 0;
        cyc();

        // starvation bound
        do_reset();
        iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h200;
        n_done = 0;
        streak_at_fetch = -1;
        for (int j = 0; j < 8; j++) seq[j] = 9;
        for (int c = 0; c < 20; c++) begin
            ram_ack = m_busy;
            at_neg();
            if (n_done < 8 && !dwait) begin
                seq[n_done] = 1; n_done++;
            end else if (n_done < 8 && !iwait) begin
                seq[n_done] = 0; n_done++;
                streak_at_fetch = int'(dbg_dstreak);
            end
            cyc();
        end
        for (int j = 0; j < 8; j++) chk("starve_seq", 32'(seq[j]), 32'(exp_seq[j]));
        chk("starve_streak_fetch", 32'(streak_at_fetch), 32'd0);
        iREN = 0; dREN = 0; ram_ack = 0;
        cyc();
        cyc();

        // read+write collision
        do_reset();
        dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h1234;
        cyc();
        for (int k = 0; k < 3; k++) begin
            ram_ack = (k == 2);
            at_neg();
            chk("coll_wen", 32'(ramWEN), 32'd1);
            chk("coll_ren", 32'(ramREN), 32'd0);
            cyc();
        end
        dREN = 0; dWEN = 0; ram_ack = 0;
        cyc();

        // reset mid-grant, then spurious ack
        do_reset();
        iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h500;
        cyc();
        at_neg();
        chk("mrst_grant_addr", ramaddr, 32'h500);
        cyc();
        RST = 1;
        cyc();
        RST = 0; iREN = 0; dREN = 0; ram_ack = 1;
        at_neg();
        chk("mrst_strobes", 32'({ramREN, ramWEN}), 32'd0);
        chk("mrst_iwait", 32'(iwait), 32'd1);
        chk("mrst_dwait", 32'(dwait), 32'd1);
        chk("mrst_state", 32'(dbg_state), 32'(IDLE));
        cyc();
        ram_ack = 0;
        at_neg();
        chk("mrst_after_ack_state", 32'(dbg_state), 32'(IDLE));
        chk("mrst_after_ack_ren", 32'(ramREN), 32'd0);
        cyc();

        // request withdrawal mid-grant
        do_reset();
        dREN = 1; daddr = 32'h600;
        cyc();
        dREN = 0;
        for (int k = 0; k < 4; k++) begin
            daddr = 32'h600 + 32'(4 * (k + 1));
            ram_ack = (k == 3);
            at_neg();
            chk("wd_addr", ramaddr, 32'h600);
            chk("wd_ren", 32'(ramREN), 32'd1);
            chk("wd_dwait", 32'(dwait), (k == 3) ? 32'd0 : 32'd1);
            cyc();
        end
        ram_ack = 0;
        at_neg();
        chk("wd_idle", 32'(dbg_state), 32'(IDLE));
        cyc();

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch path (imem) and the data-memory path (dmem) of the pipelined MIPS datapath.
- It sequences one RAM access at a time and holds the losing requester in wait.
- Data requests have priority. A bounded starvation counter guarantees forward progress of instruction fetch.
- Sits between the datapath/cache interface signals and the RAM model.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants issued while an instruction request is pending before instruction fetch is forced to win.
- ADDR_W, 32: address and data width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- iREN  in  1  instruction read request; held by requester until iwait=0.
- iaddr  in  ADDR_W  instruction address.
- iload  out  ADDR_W  instruction data, equal to ramload; valid only in the cycle iwait=0.
- iwait  out  1  1 = instruction access not complete.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both are asserted.
- daddr  in  ADDR_W  data address.
- dstore  in  ADDR_W  data to write.
- dload  out  ADDR_W  read data, equal to ramload; valid only in the cycle dwait=0.
- dwait  out  1  1 = data access not complete.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ram_ack  in  1  single-cycle pulse: current RAM access complete.

Behaviour:
- FSM states: IDLE, IGNT, DGNT. Registers: state, latched op {addr, store, is_write}, dstreak counter of width clog2(STARVE_MAX+1).
- Reset (RST=1 at a rising edge):
  - state=IDLE, dstreak=0, latched op=0.
  - Outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
  - iload and dload are always continuous pass-throughs of ramload.
  - Reset mid-access abandons the transaction; a later ram_ack seen in IDLE is ignored.
- IDLE, decision made each cycle:
  - dpend = dREN|dWEN.
  - If dpend and not (iREN and dstreak==STARVE_MAX): go to DGNT, latch daddr/dstore/is_write=dWEN.
  - Else if iREN: go to IGNT, latch iaddr, is_write=0.
  - Else stay in IDLE.
- dstreak update at each grant:
  - Data grant with iREN high: dstreak+1, saturating at STARVE_MAX.
  - Data grant with iREN low: dstreak cleared.
  - Instruction grant: dstreak cleared.
- IGNT/DGNT outputs:
  - ramaddr = latched addr.
  - ramREN = ~is_write, ramWEN = is_write.
  - ramstore = latched store in DGNT, 0 in IGNT.
  - Strobes are driven from registered state only, with no combinational path from requests.
- Completion:
  - In IGNT with ram_ack=1: iwait=0 that cycle, next state IDLE.
  - In DGNT with ram_ack=1: dwait=0 that cycle, next state IDLE.
  - Otherwise both waits stay 1.
- Latency: 1 arbitration cycle + RAM latency. Minimum 2 cycles per access when ram_ack comes in the first granted cycle. Back-to-back accesses always pass through IDLE.
- Request deassertion mid-grant (e.g. a pipeline flush) does not abort the access. It completes, and the wait still pulses low on ram_ack.
- Latched fields are frozen for the whole grant; requester address changes mid-grant do not reach the RAM.
- ram_ack in IDLE has no effect.
- ramREN and ramWEN are never both high. They are never high in IDLE.

Decomposition:
- Shared package mem_arb_pkg: enum arb_state_t {IDLE, IGNT, DGNT}; localparam default STARVE_MAX.
- Data width uses word_t from cpu_types_pkg.
- No sub-module; starvation counter and FSM live in one module.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40; ram_ack 3 cycles after grant. Required: ramREN=1, ramaddr=0x40 from cycle 1; iwait=0 with iload=ramload=0x8C010004 on the ack cycle; next cycle IDLE, strobes low.
- Simultaneous requests: iREN=1 and dWEN=1 (daddr=0x100, dstore=0xDEADBEEF). Required: DGNT first with ramWEN=1 and ramstore=0xDEADBEEF; after ack, IGNT for 0x40; iwait stays 1 until its own ack.
- Starvation, STARVE_MAX=4: iREN held and dREN held continuously. Required: exactly 4 data grants, then 1 instruction grant, then data resumes; dstreak returns to 0.
- Read+write collision: dREN=dWEN=1. Required: ramWEN=1, ramREN=0 throughout the grant.
- Mid-grant reset and spurious ack: RST pulsed during DGNT before ack. Required: next cycle strobes 0, iwait=dwait=1, state IDLE; a subsequent ram_ack pulse is ignored.
- Request withdrawal: dREN dropped while in DGNT. Required: the access continues and dwait pulses 0 on ram_ack; the address on ramaddr stays unchanged although daddr toggles.
